mem_store_forward: RTL and testbench

MEM_STORE_FORWARD -- requirements
Module: mem_store_forward

---
 rtl/mem_store_forward.sv | 98 +++++++++
 tb/tb_mem_store_forward.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_forward.sv
// Store-data forwarding for the MEM stage: corrects a store's data from the
// WB result or from a short history of retired register writes, with event counters.
module mem_store_forward #(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_memtoreg,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic              mem_memwrite,
  input  logic [REG_AW-1:0] mem_rt,
  input  logic [DATA_W-1:0] mem_rt_data,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] store_data,
  output logic [1:0]        fwd_sel,
  output logic [2:0]        hist_idx,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  hist_cnt
);

  localparam logic [1:0] SelNone = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelAlu  = 2'b10;
  localparam logic [1:0] SelHist = 2'b11;

  logic              histValid [DEPTH];
  logic [REG_AW-1:0] histRd    [DEPTH];
  logic [DATA_W-1:0] histData  [DEPTH];

  logic [DATA_W-1:0] wbVal;
  logic              wbWrite;
  logic              lookupActive;

  assign wbVal        = wb_memtoreg ? wb_mem_data : wb_alu_result;
  assign wbWrite      = wb_we && (wb_rd != '0);
  assign lookupActive = mem_memwrite && (mem_rt != '0);

  // Oldest-to-newest scan so the lowest matching index is the last one written.
  always_comb begin
    fwd_sel    = SelNone;
    store_data = mem_rt_data;
    hist_idx   = 3'd0;
    if (lookupActive) begin
      if (wbWrite && (wb_rd == mem_rt)) begin
        fwd_sel    = wb_memtoreg ? SelLoad : SelAlu;
        store_data = wbVal;
      end else begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (histValid[i] && (histRd[i] == mem_rt)) begin
            fwd_sel    = SelHist;
            store_data = histData[i];
            hist_idx   = 3'(i);
          end
        end
      end
    end
  end

  // A push shifts the history and kills older copies of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        histValid[i] <= 1'b0;
        histRd[i]    <= '0;
        histData[i]  <= '0;
      end
    end else if (wbWrite) begin
      for (int i = 1; i < DEPTH; i++) begin
        histValid[i] <= histValid[i-1] && (histRd[i-1] != wb_rd);
        histRd[i]    <= histRd[i-1];
        histData[i]  <= histData[i-1];
      end
      histValid[0] <= 1'b1;
      histRd[0]    <= wb_rd;
      histData[0]  <= wbVal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt  <= '0;
      hist_cnt <= '0;
    end else if (cnt_clr) begin
      fwd_cnt  <= '0;
      hist_cnt <= '0;
    end else begin
      if ((fwd_sel != SelNone) && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 1'b1;
      if ((fwd_sel == SelHist) && (hist_cnt != '1)) hist_cnt <= hist_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_store_forward.sv
// Directed bench for mem_store_forward: WB/history forwarding, invalidation,
// saturation, clear priority and asynchronous reset.
module tb_mem_store_forward;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_memtoreg;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_mem_data;
  logic              mem_memwrite;
  logic [REG_AW-1:0] mem_rt;
  logic [DATA_W-1:0] mem_rt_data;
  logic              cnt_clr;
  logic [DATA_W-1:0] store_data;
  logic [1:0]        fwd_sel;
  logic [2:0]        hist_idx;
  logic [CNT_W-1:0]  fwd_cnt;
  logic [CNT_W-1:0]  hist_cnt;

  int compared;
  int mismatched;
  logic [DATA_W-1:0] exp_q[$];

  mem_store_forward #(
    .REG_AW(REG_AW), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .mem_memwrite(mem_memwrite), .mem_rt(mem_rt), .mem_rt_data(mem_rt_data),
    .cnt_clr(cnt_clr),
    .store_data(store_data), .fwd_sel(fwd_sel), .hist_idx(hist_idx),
    .fwd_cnt(fwd_cnt), .hist_cnt(hist_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expVal);
    compared++;
    if (obs !== expVal) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expVal);
    end
  endtask

  // driver tasks
  task automatic setIdle();
    wb_we = 1'b0; wb_rd = '0; wb_memtoreg = 1'b0;
    wb_alu_result = '0; wb_mem_data = '0;
    mem_memwrite = 1'b0; mem_rt = '0; mem_rt_data = '0; cnt_clr = 1'b0;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic driveWrite(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] data,
                            input logic fromMem);
    wb_we = 1'b1; wb_rd = rd; wb_memtoreg = fromMem;
    wb_mem_data   = fromMem ? data : 32'hBAD0_BAD0;
    wb_alu_result = fromMem ? 32'hDEAD_0000 : data;
  endtask

  task automatic driveStore(input logic [REG_AW-1:0] rt, input logic [DATA_W-1:0] data);
    mem_memwrite = 1'b1; mem_rt = rt; mem_rt_data = data;
  endtask

  task automatic doWrite(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] data,
                         input logic fromMem);
    setIdle();
    driveWrite(rd, data, fromMem);
    stepClk();
    setIdle();
  endtask

  task automatic checkLookup(input string tag, input logic [1:0] expSel,
                             input logic [DATA_W-1:0] expData, input logic [2:0] expIdx);
    #2;
    checkVal({tag, "_sel"}, 64'(fwd_sel), 64'(expSel));
    checkVal({tag, "_data"}, 64'(store_data), 64'(expData));
    checkVal({tag, "_idx"}, 64'(hist_idx), 64'(expIdx));
  endtask

  task automatic checkCnt(input string tag, input logic [CNT_W-1:0] expFwd,
                          input logic [CNT_W-1:0] expHist);
    checkVal({tag, "_fwd_cnt"}, 64'(fwd_cnt), 64'(expFwd));
    checkVal({tag, "_hist_cnt"}, 64'(hist_cnt), 64'(expHist));
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    setIdle();
    rst_n = 1'b0;
    #12;
    checkCnt("reset", 16'd0, 16'd0);
    driveStore(5'd4, 32'h0000_0444);
    checkLookup("reset_lookup", 2'b00, 32'h0000_0444, 3'd0);
    setIdle();
    @(negedge clk);
    rst_n = 1'b1;
    stepClk();

    // Scenario 1: WB load data forwarded and pushed at the same edge
    driveWrite(5'd5, 32'hAAAA_0001, 1'b1);
    driveStore(5'd5, 32'h0000_0055);
    checkLookup("s1_wb_load", 2'b01, 32'hAAAA_0001, 3'd0);
    checkCnt("s1_pre", 16'd0, 16'd0);
    stepClk();
    checkCnt("s1_post", 16'd1, 16'd0);

    // WB ALU result path; history becomes [r6, r5]
    setIdle();
    driveWrite(5'd6, 32'h0000_600D, 1'b0);
    driveStore(5'd6, 32'h0000_0066);
    checkLookup("s1_wb_alu", 2'b10, 32'h0000_600D, 3'd0);
    stepClk();
    checkCnt("s1_alu", 16'd2, 16'd0);

    setIdle();
    driveStore(5'd5, 32'h0000_0055);
    checkLookup("s1_hist_r5", 2'b11, 32'hAAAA_0001, 3'd1);
    stepClk();
    checkCnt("s1_hist", 16'd3, 16'd1);

    setIdle();
    mem_rt = 5'd5; mem_rt_data = 32'h0000_0077;
    checkLookup("inactive", 2'b00, 32'h0000_0077, 3'd0);
    stepClk();
    checkCnt("inactive", 16'd3, 16'd1);

    // Scenario 2: history hit at the newest entry
    doWrite(5'd7, 32'h0000_1234, 1'b0);
    driveStore(5'd7, 32'h0);
    checkLookup("s2", 2'b11, 32'h0000_1234, 3'd0);
    stepClk();
    checkCnt("s2", 16'd4, 16'd2);

    // Scenario 3: rewrite of r3, then r3 ages out after DEPTH other writes
    doWrite(5'd3, 32'h11, 1'b0);
    doWrite(5'd3, 32'h22, 1'b0);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h0000_0333);
    driveStore(5'd3, 32'h0000_0333);
    #2;
    checkVal("s3_newest_sel", 64'(fwd_sel), 64'(2'b11));
    checkVal("s3_newest_data", 64'(store_data), 64'(exp_q.pop_front()));
    checkVal("s3_newest_idx", 64'(hist_idx), 64'(3'd0));
    stepClk();
    checkCnt("s3_a", 16'd5, 16'd3);
    for (int k = 0; k < DEPTH; k++) begin
      doWrite(5'(10 + k), 32'(32'h100 + k), 1'b0);
      driveStore(5'd3, 32'h0000_0333);
      #2;
      checkVal($sformatf("s3_age%0d_data", k), 64'(store_data), 64'(exp_q.pop_front()));
      checkVal($sformatf("s3_age%0d_sel", k), 64'(fwd_sel), (k < DEPTH - 1) ? 64'(2'b11) : 64'(2'b00));
      checkVal($sformatf("s3_age%0d_idx", k), 64'(hist_idx), (k < DEPTH - 1) ? 64'(k + 1) : 64'(0));
      stepClk();
    end
    checkCnt("s3_b", 16'd7, 16'd5);

    // Scenario 4: r0 writes and stores are ignored
    setIdle();
    driveWrite(5'd0, 32'h0000_0099, 1'b0);
    driveStore(5'd0, 32'h0000_0044);
    checkLookup("s4_r0", 2'b00, 32'h0000_0044, 3'd0);
    stepClk();
    checkCnt("s4", 16'd7, 16'd5);
    driveStore(5'd12, 32'h0);
    checkLookup("s4_nopush", 2'b11, 32'h0000_0102, 3'd0);
    stepClk();
    checkCnt("s4_nopush", 16'd8, 16'd6);

    // Scenario 6: asynchronous reset mid-cycle wipes history and counters
    doWrite(5'd9, 32'h0000_0909, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkCnt("s6_async", 16'd0, 16'd0);
    driveStore(5'd9, 32'h0000_1357);
    checkLookup("s6_in_reset", 2'b00, 32'h0000_1357, 3'd0);
    stepClk();
    checkCnt("s6_no_count", 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    setIdle();
    stepClk();
    driveStore(5'd9, 32'h0000_1357);
    checkLookup("s6_after", 2'b00, 32'h0000_1357, 3'd0);
    stepClk();
    checkCnt("s6_after", 16'd0, 16'd0);

    // Scenario 5: saturate fwd_cnt with WB forwards, then clear beats increment
    setIdle();
    driveWrite(5'd1, 32'h0000_0F0F, 1'b0);
    driveStore(5'd1, 32'h0);
    for (int k = 0; k < 65534; k++) stepClk();
    checkCnt("s5_near", 16'hFFFE, 16'd0);
    stepClk();
    checkCnt("s5_sat", 16'hFFFF, 16'd0);
    stepClk();
    checkCnt("s5_hold", 16'hFFFF, 16'd0);
    cnt_clr = 1'b1;
    stepClk();
    checkCnt("s5_clr", 16'd0, 16'd0);
    setIdle();
    driveStore(5'd1, 32'h0);
    checkLookup("s5_hist_kept", 2'b11, 32'h0000_0F0F, 3'd0);
    stepClk();
    checkCnt("s5_final", 16'd1, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
